// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer.
// This file holds the command codes, FSM states, error-bit positions and default widths.
package alu_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_RES_W  = 32;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_MUL = 4'd3;
    localparam logic [3:0] CMD_DIV = 4'd4;
    localparam logic [3:0] CMD_MOD = 4'd5;

    localparam int ERR_OVF = 0;
    localparam int ERR_DBZ = 1;

    localparam logic [1:0] ERR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_e;

    function automatic logic cmd_is_legal(input logic [3:0] cmd);
        return (cmd >= CMD_ADD) && (cmd <= CMD_MOD);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Operation request and result handshake between a producer/consumer and the sequencer.
// The master modport is the producer/consumer side; the slave modport is the sequencer side.
interface alu_op_sequencer_if
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RES_W  = DEF_RES_W
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [3:0]        in_cmd;
    logic              in_acc;

    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_result;
    logic [1:0]        out_error;

    modport master (
        output in_valid, in_a, in_b, in_cmd, in_acc, out_ready,
        input  in_ready, out_valid, out_result, out_error
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cmd, in_acc, out_ready,
        output in_ready, out_valid, out_result, out_error
    );

endinterface

// File: rtl/alu_op_sequencer.sv
// Sequencer for an external combinational ALU. It registers operands, waits SETTLE cycles,
// captures a masked result and keeps an accumulator and sticky error flags.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RES_W  = DEF_RES_W,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_op_sequencer_if.slave bus,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [3:0]        alu_cmd_o,
    input  logic [RES_W-1:0]  alu_result_i,
    input  logic [1:0]        alu_error_i,
    output logic [RES_W-1:0]  acc_o,
    output logic [1:0]        err_sticky_o,
    input  logic              clr_err_i
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [3:0]        alu_cmd_q, alu_cmd_d;
    logic              illegal_q, illegal_d;
    logic [RES_W-1:0]  out_result_q, out_result_d;
    logic [1:0]        out_error_q, out_error_d;
    logic              out_valid_q, out_valid_d;
    logic [RES_W-1:0]  acc_q, acc_d;
    logic [1:0]        err_sticky_q, err_sticky_d;

    logic              capture;
    logic [1:0]        cap_err;
    logic [RES_W-1:0]  cap_res;
    logic [1:0]        masked_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cmd_q    <= '0;
            illegal_q    <= 1'b0;
            out_result_q <= '0;
            out_error_q  <= '0;
            out_valid_q  <= 1'b0;
            acc_q        <= '0;
            err_sticky_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_cmd_q    <= alu_cmd_d;
            illegal_q    <= illegal_d;
            out_result_q <= out_result_d;
            out_error_q  <= out_error_d;
            out_valid_q  <= out_valid_d;
            acc_q        <= acc_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_cmd_d    = alu_cmd_q;
        illegal_d    = illegal_q;
        out_result_d = out_result_q;
        out_error_d  = out_error_q;
        out_valid_d  = out_valid_q;
        acc_d        = acc_q;
        capture      = 1'b0;
        cap_err      = '0;
        cap_res      = '0;

        // Overflow only means something for add/sub, divide-by-zero only for div/mod.
        masked_err          = '0;
        masked_err[ERR_OVF] = alu_error_i[ERR_OVF] &&
                              ((alu_cmd_q == CMD_ADD) || (alu_cmd_q == CMD_SUB));
        masked_err[ERR_DBZ] = alu_error_i[ERR_DBZ] &&
                              ((alu_cmd_q == CMD_DIV) || (alu_cmd_q == CMD_MOD));

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    cnt_d   = '0;
                    state_d = ISSUE;
                    if (cmd_is_legal(bus.in_cmd)) begin
                        alu_a_d   = bus.in_acc ? acc_q[DATA_W-1:0] : bus.in_a;
                        alu_b_d   = bus.in_b;
                        alu_cmd_d = bus.in_cmd;
                        illegal_d = 1'b0;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (illegal_q) begin
                    capture = 1'b1;
                    cap_err = ERR_ILLEGAL;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_d == SETTLE_CNT) begin
                        capture = 1'b1;
                        cap_err = masked_err;
                        cap_res = masked_err[ERR_DBZ] ? '0 : alu_result_i;
                    end
                end
                if (capture) begin
                    out_result_d = cap_res;
                    out_error_d  = cap_err;
                    out_valid_d  = 1'b1;
                    state_d      = HOLD;
                    if (cap_err == 2'b00) begin
                        acc_d = alu_result_i;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A clear on the capture edge still keeps the freshly captured flags.
        err_sticky_d = (clr_err_i ? 2'b00 : err_sticky_q) | (capture ? cap_err : 2'b00);
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_error  = out_error_q;
    assign alu_a_o        = alu_a_q;
    assign alu_b_o        = alu_b_q;
    assign alu_cmd_o      = alu_cmd_q;
    assign acc_o          = acc_q;
    assign err_sticky_o   = err_sticky_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: a behavioural ALU drives the result inputs,
// and a transaction-level model predicts results, flags, accumulator and sticky errors.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int DW     = 16;
    localparam int RW     = 32;
    localparam int SETTLE = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] aluA, aluB;
    logic [3:0]    aluCmd;
    logic [RW-1:0] aluResult;
    logic [1:0]    aluError;
    logic [RW-1:0] acc;
    logic [1:0]    errSticky;
    logic          clrErr = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [RW-1:0] mAcc = '0;
    logic [1:0]    mSticky = '0;
    logic [RW-1:0] expRes;
    logic [1:0]    expErr;
    int            expLat;
    logic [RW-1:0] lastRes;
    logic [1:0]    lastErr;

    alu_op_sequencer_if #(.DATA_W(DW), .RES_W(RW)) bus ();

    alu_op_sequencer #(.DATA_W(DW), .RES_W(RW), .SETTLE(SETTLE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_a_o      (aluA),
        .alu_b_o      (aluB),
        .alu_cmd_o    (aluCmd),
        .alu_result_i (aluResult),
        .alu_error_i  (aluError),
        .acc_o        (acc),
        .err_sticky_o (errSticky),
        .clr_err_i    (clrErr)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: raises dbz whenever b is zero and overflow whenever the value leaves 16 bits,
    // so the sequencer's masking is exercised on every command.
    always_comb begin
        aluResult = '0;
        aluError  = '0;
        case (aluCmd)
            4'd1: begin aluResult = {16'b0, aluA} + {16'b0, aluB}; aluError[0] = aluResult[16]; end
            4'd2: begin aluResult = {16'b0, aluA} - {16'b0, aluB}; aluError[0] = (aluA < aluB); end
            4'd3: begin aluResult = {16'b0, aluA} * {16'b0, aluB}; aluError[0] = |aluResult[31:16]; end
            4'd4: aluResult = (aluB == 0) ? 32'hDEAD_BEEF : {16'b0, aluA / aluB};
            4'd5: aluResult = (aluB == 0) ? 32'hDEAD_BEEF : {16'b0, aluA % aluB};
            default: aluResult = 32'hBAD0_BAD0;
        endcase
        if (aluB == 0) aluError[1] = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level prediction straight from the command semantics.
    task automatic modelOp(input logic [15:0] a, input logic [15:0] b, input logic [3:0] cmd,
                           input bit useAcc, input bit clrAtCap, output logic [15:0] aEff);
        longint ra, rb, r;
        aEff   = useAcc ? mAcc[15:0] : a;
        ra     = longint'(aEff);
        rb     = longint'(b);
        r      = 0;
        expErr = 2'b00;
        if (cmd == 4'd0 || cmd > 4'd5) begin
            expRes = '0;
            expErr = 2'b11;
            expLat = 1;
        end else begin
            expLat = SETTLE;
            case (cmd)
                4'd1: begin r = ra + rb; expErr[0] = (r > 65535); end
                4'd2: begin r = ra - rb; expErr[0] = (ra < rb); end
                4'd3: r = ra * rb;
                4'd4: if (rb == 0) expErr[1] = 1'b1; else r = ra / rb;
                default: if (rb == 0) expErr[1] = 1'b1; else r = ra % rb;
            endcase
            expRes = r[31:0];
        end
        if (expErr == 2'b00) mAcc = expRes;
        mSticky = clrAtCap ? expErr : (mSticky | expErr);
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [3:0] cmd,
                                 input bit useAcc, input int holdCycles, input bit clrAtCap,
                                 input bit clrAtRelease);
        logic [15:0] aEff, prevA, prevB;
        logic [3:0]  prevCmd;
        int          waitCnt, lat;
        waitCnt = 0;
        while (!bus.in_ready && waitCnt < 20) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput("in_ready_idle", 32'(bus.in_ready), 32'd1);
        prevA = aluA; prevB = aluB; prevCmd = aluCmd;
        modelOp(a, b, cmd, useAcc, clrAtCap, aEff);

        @(negedge clk);
        bus.in_a = a; bus.in_b = b; bus.in_cmd = cmd; bus.in_acc = useAcc; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        if (expLat == 1) begin
            checkOutput("alu_a_kept", 32'(aluA), 32'(prevA));
            checkOutput("alu_cmd_kept", 32'(aluCmd), 32'(prevCmd));
        end else begin
            checkOutput("alu_a", 32'(aluA), 32'(aEff));
            checkOutput("alu_b", 32'(aluB), 32'(b));
            checkOutput("alu_cmd", 32'(aluCmd), 32'(cmd));
        end

        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            if (clrAtCap && (lat + 1 == expLat)) clrErr = 1'b1;
            @(posedge clk); #1;
            clrErr = 1'b0;
            lat++;
        end
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("out_result", bus.out_result, expRes);
        checkOutput("out_error", 32'(bus.out_error), 32'(expErr));
        checkOutput("acc", acc, mAcc);
        checkOutput("err_sticky", 32'(errSticky), 32'(mSticky));
        lastRes = bus.out_result;
        lastErr = bus.out_error;

        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_a = 16'($urandom); bus.in_b = 16'($urandom);
            bus.in_cmd = 4'd1; bus.in_acc = 1'b0;
            @(posedge clk); #1;
            checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("hold_result", bus.out_result, expRes);
            checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end

        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        clrErr        = clrAtRelease;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        clrErr        = 1'b0;
        if (clrAtRelease) mSticky = 2'b00;
        checkOutput("release_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("release_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("release_sticky", 32'(errSticky), 32'(mSticky));
        checkOutput("alu_a_after", 32'(aluA), (expLat == 1) ? 32'(prevA) : 32'(aEff));
        if (expLat == 1) checkOutput("alu_b_after", 32'(aluB), 32'(prevB));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cmd = '0; bus.in_acc = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_acc", acc, 32'd0);
        checkOutput("rst_sticky", 32'(errSticky), 32'd0);
        checkOutput("rst_alu_a", 32'(aluA), 32'd0);
        checkOutput("rst_alu_cmd", 32'(aluCmd), 32'd0);
        checkOutput("rst_out_result", bus.out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        applyStimulus(16'd249, 16'd69, 4'd1, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("lit_add", lastRes, 32'd318);
        applyStimulus(16'd249, 16'd69, 4'd2, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("lit_sub", lastRes, 32'd180);
        applyStimulus(16'd249, 16'd69, 4'd3, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("lit_mul", lastRes, 32'd17181);
        checkOutput("lit_mul_err", 32'(lastErr), 32'd0);
        applyStimulus(16'd249, 16'd69, 4'd4, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("lit_div", lastRes, 32'd3);

        applyStimulus(16'd500, 16'd0, 4'd4, 1'b0, 0, 1'b0, 1'b1);
        checkOutput("lit_dbz_res", lastRes, 32'd0);
        checkOutput("lit_dbz_err", 32'(lastErr), 32'd2);
        checkOutput("lit_dbz_cleared", 32'(errSticky), 32'd0);

        applyStimulus(16'd10, 16'd5, 4'd1, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("lit_acc15", acc, 32'd15);
        applyStimulus(16'hFFFF, 16'd7, 4'd1, 1'b1, 0, 1'b0, 1'b0);
        checkOutput("lit_acc22", acc, 32'd22);

        applyStimulus(16'd1000, 16'd3, 4'd3, 1'b0, 5, 1'b0, 1'b0);

        applyStimulus(16'd500, 16'd0, 4'd5, 1'b0, 0, 1'b0, 1'b0);
        applyStimulus(16'd3, 16'd5, 4'd2, 1'b0, 0, 1'b1, 1'b0);
        checkOutput("lit_clr_on_capture", 32'(errSticky), 32'd1);

        applyStimulus(16'd77, 16'd88, 4'd9, 1'b0, 1, 1'b0, 1'b1);
        checkOutput("lit_illegal_err", 32'(lastErr), 32'd3);

        // Reset in the middle of an operation: nothing from it may surface.
        @(negedge clk);
        bus.in_a = 16'd1; bus.in_b = 16'd2; bus.in_cmd = 4'd1; bus.in_acc = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        mAcc = '0;
        mSticky = '0;
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_acc", acc, 32'd0);
        checkOutput("midrst_alu_a", 32'(aluA), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midrst_no_output", 32'(bus.out_valid), 32'd0);

        for (int n = 0; n < 40; n++) begin
            logic [3:0]  rc;
            logic [15:0] ra, rb;
            int          pick;
            pick = int'($urandom_range(0, 9));
            rc   = (pick <= 4) ? 4'(pick + 1) : 4'($urandom_range(0, 15));
            ra   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            rb   = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            applyStimulus(ra, rb, rc, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter: DATA_W, 16, operand width.
REQ-002 Parameter: RES_W, 32, result width.
REQ-003 Parameter: SETTLE, 2, cycles (1..15) the ALU inputs are held stable before the result is captured.
REQ-004 clk  in  1  the single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  an operation is offered.
REQ-007 in_ready  out  1  the sequencer accepts an operation.
REQ-008 in_a / in_b  in  DATA_W  operands.
REQ-009 in_cmd  in  4  command: 1 add, 2 sub, 3 mul, 4 div, 5 mod.
REQ-010 in_acc  in  1  when 1, replace in_a with acc[15:0].
REQ-011 alu_a / alu_b  out  DATA_W  registered operands to the ALU.
REQ-012 alu_cmd  out  4  registered command to the ALU.
REQ-013 alu_result  in  RES_W  combinational ALU result.
REQ-014 alu_error  in  2  ALU error flags {dbz, overflow}.
REQ-015 out_valid  out  1  a result is presented.
REQ-016 out_ready  in  1  the consumer accepts the result.
REQ-017 out_result  out  RES_W  captured result.
REQ-018 out_error  out  2  captured error flags.
REQ-019 acc  out  RES_W  accumulator.
REQ-020 err_sticky  out  2  OR of all out_error values since the last clear.
REQ-021 clr_err  in  1  synchronous clear of err_sticky.

Function
REQ-022 FSM states: IDLE, ISSUE, HOLD; in_ready SHALL be 1 only in IDLE.
REQ-023 Accept edge (IDLE, in_valid=1) SHALL load alu_a, alu_b and alu_cmd, clear the settle counter, and enter ISSUE.
REQ-024 ISSUE SHALL count SETTLE cycles; on the edge the count reaches SETTLE, it SHALL capture out_result/out_error, set out_valid, and enter HOLD. Accept-to-out_valid latency is exactly SETTLE cycles.
REQ-025 HOLD: out_valid=1 with out_result/out_error stable until out_valid&out_ready, then IDLE with out_valid=0; the earliest next accept is the cycle after.
REQ-026 Overflow masking: out_error[0]=alu_error[0] only for cmd 1/2, else 0.
REQ-027 dbz: out_error[1]=alu_error[1] only for cmd 4/5; when set, out_result=0.
REQ-028 Illegal cmd (0, 6..15): accepted, no ALU settle; enters HOLD on the next edge with out_result=0, out_error=2'b11, alu_* unchanged.
REQ-029 Capture with out_error==0 SHALL load acc with alu_result; a capture with any error SHALL leave acc unchanged.
REQ-030 in_acc=1 SHALL drive alu_a from acc[15:0] sampled at the accept edge.
REQ-031 err_sticky |= out_error at each capture; clr_err clears it; a capture and clr_err on the same edge SHALL leave the newly captured bits set.
REQ-032 Inputs other than clr_err/out_ready SHALL be ignored outside IDLE.

Reset
REQ-033 rst_n low at any time SHALL immediately force IDLE and zero in all registers: alu_a, alu_b, alu_cmd, out_result, out_error, out_valid, acc, err_sticky, and the settle counter.
REQ-034 Reset mid-ISSUE/HOLD SHALL discard the operation with no partial output.
REQ-035 in_ready SHALL be 1 on the first edge after rst_n deasserts.

Structure
REQ-036 Shared package alu_pkg SHALL hold the command codes (CMD_NOP..CMD_MOD), the state enum, the error-bit indices, DATA_W/RES_W defaults, and ERR_ILLEGAL=2'b11.
REQ-037 Settle counter and FSM SHALL live in one module; the ALU itself is instantiated alongside by the parent, not inside; no sub-module.

Verification
REQ-038 A=249, B=69, cmd 1 -> out_valid exactly 2 cycles after accept, result 318, error 00; cmd 2 -> 180; cmd 3 -> 17181, error 00 (overflow masked); cmd 4 -> 3.
REQ-039 A=500, B=0, cmd 4 -> result 0, error 10, acc unchanged, err_sticky=10; clr_err -> 00.
REQ-040 Accumulate: A=10, B=5 add (acc=15); then in_acc=1, B=7 add -> alu_a=15, result 22, acc=22.
REQ-041 Backpressure: out_ready held 0 for 5 cycles -> out_valid and out_result stable, in_ready=0, a new in_valid is ignored; release -> IDLE on the next edge.
REQ-042 cmd 9 -> HOLD one edge after accept, result 0, error 11; rst_n pulsed low during ISSUE -> out_valid=0 and acc=0 immediately, in_ready=1 after release.
